sr_cmd_gen: RTL and testbench
=============================

SR_CMD_GEN -- requirements
Module: sr_cmd_gen

Interface
REQ-001 SHALL have parameter PULSE_W, default 2, meaning width in clk cycles of each s/r pulse (legal 1..15).
REQ-002 SHALL have parameter GUARD_W, default 1, meaning idle gap in cycles with s=r=0 after each pulse (legal 1..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port set_req  input  1  request to set the downstream SR flip-flop (q=1).
REQ-006 SHALL have port clr_req  input  1  request to clear the downstream SR flip-flop (q=0).
REQ-007 SHALL have port tog_req  input  1  request to invert the downstream flip-flop, based on the shadow state.
REQ-008 SHALL have port clr_flags  input  1  synchronous clear of the sticky error flags.
REQ-009 SHALL have port s  output  1  set drive to the downstream SR flip-flop.
REQ-010 SHALL have port r  output  1  reset drive to the downstream SR flip-flop.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 SHALL have port shadow_q  output  1  commanded flip-flop state after the last completed pulse.
REQ-013 SHALL have port err_conflict  output  1  sticky flag: conflicting requests were seen in the same cycle.
REQ-014 SHALL have port err_ovf  output  1  sticky flag: a pending request was overwritten.

Function
REQ-015 s, r, busy SHALL be registered outputs; s and r SHALL never be high in the same cycle.
REQ-016 FSM states SHALL be INIT, IDLE, SET_P, CLR_P, GUARD.
REQ-017 INIT SHALL drive r=1 for PULSE_W cycles, then enter GUARD with shadow_q=0, forcing the latch to a known state.
REQ-018 A request sampled in IDLE at edge N SHALL drive the pulse on cycles N+1..N+PULSE_W, then GUARD_W cycles of s=r=0, then IDLE.
REQ-019 tog_req SHALL resolve to SET_P when shadow_q=0 and to CLR_P when shadow_q=1, using the value at the sampling edge.
REQ-020 shadow_q SHALL update on the last pulse cycle's exit edge (SET_P->1, CLR_P->0).
REQ-021 More than one of set_req/clr_req/tog_req high in one cycle SHALL set err_conflict and no request SHALL be taken or queued that cycle.
REQ-022 A single request arriving while busy SHALL be stored in a 1-deep pending slot and issued on GUARD exit with no IDLE cycle in between.
REQ-023 A new request arriving while the pending slot is full SHALL overwrite the slot (latest wins) and set err_ovf.
REQ-024 A set request when shadow_q=1 SHALL still issue a full pulse (no suppression).
REQ-025 The pulse and guard counter SHALL be 4 bits and SHALL count down, with no wrap past zero.
REQ-026 clr_flags SHALL clear both sticky flags; if an error occurs in the same cycle, the set SHALL win.

Reset
REQ-027 Asserting rst SHALL immediately force s=0, r=0, busy=1, shadow_q=0, err_conflict=0, err_ovf=0, pending empty, and state INIT, including mid-pulse.
REQ-028 After rst deasserts, r SHALL rise on the first clk edge and INIT SHALL run as specified in REQ-017.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the request-code enum (NONE/SET/CLR/TOG), and the counter width constant.
REQ-030 The pulse/guard down-counter SHALL be a sub-module named pulse_timer (load, count, done); the FSM, pending slot and flags SHALL stay in the top.
REQ-031 s and r SHALL connect directly to the downstream flip-flop's s and r.

Verification
REQ-032 Release rst -> r=1 on cycles 1-2, s=r=0 on cycle 3, busy low from cycle 4, shadow_q=0.
REQ-033 set_req for 1 cycle in IDLE at edge N -> s=1 on N+1..N+2, guard on N+3, shadow_q=1 and busy=0 at N+4; the downstream q reads 1.
REQ-034 tog_req twice, the second during GUARD -> second request pends, r pulse follows with no IDLE gap, final shadow_q=0.
REQ-035 set_req and clr_req in the same cycle -> no pulse, err_conflict=1 until clr_flags, then 0.
REQ-036 clr_req, set_req, tog_req on consecutive busy cycles -> err_ovf=1; only the tog request is executed after the first pulse.
REQ-037 Assert rst in the 2nd cycle of an s pulse -> s drops asynchronously, INIT runs, and s&r is never 1 throughout.

Source files
------------

// File: rtl/sr_cmd_gen_pkg.sv
// SR command generator: shared types.
// States, request codes and counter width.
package sr_cmd_gen_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SET_P = 3'd2,
    ST_CLR_P = 3'd3,
    ST_GUARD = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_SET  = 2'd1,
    REQ_CLR  = 2'd2,
    REQ_TOG  = 2'd3
  } req_t;

  // Map a request to its pulse state; toggle follows the shadow.
  function automatic state_t pulse_state(
    input req_t code,
    input logic shadow
  );
    state_t st;
    st = ST_SET_P;
    unique case (code)
      REQ_SET: st = ST_SET_P;
      REQ_CLR: st = ST_CLR_P;
      REQ_TOG: st = shadow ? ST_CLR_P : ST_SET_P;
      default: st = ST_SET_P;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/sr_cmd_gen_pulse_timer.sv
// SR command generator: pulse/guard timer.
// Loadable 4-bit down-counter, holds at zero.
module pulse_timer
  import sr_cmd_gen_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             count_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins over count; never wrap below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (count_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register; reset preloads the INIT pulse length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sr_cmd_gen.sv
// SR command generator top.
// Turns set/clr/toggle requests into guarded s/r pulses.
module sr_cmd_gen
  import sr_cmd_gen_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GUARD_W = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  input  logic tog_req,
  input  logic clr_flags,
  output logic s,
  output logic r,
  output logic busy,
  output logic shadow_q,
  output logic err_conflict,
  output logic err_ovf
);

  localparam logic [CNT_W-1:0] PW_LD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GW_LD = CNT_W'(GUARD_W - 1);

  state_t state_q;
  state_t state_d;
  req_t   pend_q;
  req_t   pend_d;
  req_t   new_code;
  req_t   pend_eff;

  logic       shadow_d;
  logic       s_q;
  logic       r_q;
  logic       busy_q;
  logic       conf_q;
  logic       conf_d;
  logic       ovf_q;
  logic       ovf_d;
  logic [1:0] n_req;
  logic       conflict;
  logic       new_vld;
  logic       ovf_set;

  logic             tim_load;
  logic [CNT_W-1:0] tim_val;
  logic             tim_count;
  logic             tim_done;

  pulse_timer #(
    .RST_VAL(PW_LD)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tim_load),
    .load_val_i(tim_val),
    .count_i   (tim_count),
    .done_o    (tim_done)
  );

  assign n_req = {1'b0, set_req}
               + {1'b0, clr_req}
               + {1'b0, tog_req};

  assign conflict = (n_req > 2'd1);

  // Decode a lone request; simultaneous ones are dropped.
  always_comb begin
    new_code = REQ_NONE;
    if (n_req == 2'd1) begin
      unique case (1'b1)
        set_req: new_code = REQ_SET;
        clr_req: new_code = REQ_CLR;
        tog_req: new_code = REQ_TOG;
        default: new_code = REQ_NONE;
      endcase
    end
  end

  assign new_vld  = (new_code != REQ_NONE);
  assign pend_eff = new_vld ? new_code : pend_q;
  assign ovf_set  = new_vld
                 && (pend_q != REQ_NONE)
                 && (state_q != ST_IDLE);

  // Sequencing: pulse, guard, then pending or idle.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    shadow_d  = shadow_q;
    tim_load  = 1'b0;
    tim_val   = PW_LD;
    tim_count = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (new_vld) begin
          state_d  = pulse_state(new_code, shadow_q);
          tim_load = 1'b1;
          tim_val  = PW_LD;
        end
      end
      ST_INIT, ST_SET_P, ST_CLR_P: begin
        if (new_vld) begin
          pend_d = new_code;
        end
        if (tim_done) begin
          state_d  = ST_GUARD;
          tim_load = 1'b1;
          tim_val  = GW_LD;
          shadow_d = (state_q == ST_SET_P);
        end else begin
          tim_count = 1'b1;
        end
      end
      ST_GUARD: begin
        if (new_vld) begin
          pend_d = new_code;
        end
        if (tim_done) begin
          if (pend_eff != REQ_NONE) begin
            state_d  = pulse_state(pend_eff, shadow_q);
            tim_load = 1'b1;
            tim_val  = PW_LD;
            pend_d   = REQ_NONE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tim_count = 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Sticky flags; a new error beats a clear.
  always_comb begin
    conf_d = conflict | (conf_q & ~clr_flags);
    ovf_d  = ovf_set  | (ovf_q  & ~clr_flags);
  end

  // Control state, pending slot and shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_INIT;
      pend_q   <= REQ_NONE;
      shadow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
    end
  end

  // Registered drives follow the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= 1'b0;
      r_q    <= 1'b0;
      busy_q <= 1'b1;
    end else begin
      s_q    <= (state_q == ST_SET_P);
      r_q    <= (state_q == ST_INIT)
             || (state_q == ST_CLR_P);
      busy_q <= (state_q != ST_IDLE);
    end
  end

  // Error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conf_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      conf_q <= conf_d;
      ovf_q  <= ovf_d;
    end
  end

  assign s            = s_q;
  assign r            = r_q;
  assign busy         = busy_q;
  assign err_conflict = conf_q;
  assign err_ovf      = ovf_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: directed scenarios plus random traffic
// checked against a per-cycle output schedule model.
module tb_sr_cmd_gen;

  localparam int PW = 2;
  localparam int GW = 1;

  logic clk = 1'b0;
  logic rst;
  logic set_req;
  logic clr_req;
  logic tog_req;
  logic clr_flags;
  logic s;
  logic r;
  logic busy;
  logic shadow_q;
  logic err_conflict;
  logic err_ovf;
  logic q_ff = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  sr_cmd_gen #(
    .PULSE_W(PW),
    .GUARD_W(GW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .set_req     (set_req),
    .clr_req     (clr_req),
    .tog_req     (tog_req),
    .clr_flags   (clr_flags),
    .s           (s),
    .r           (r),
    .busy        (busy),
    .shadow_q    (shadow_q),
    .err_conflict(err_conflict),
    .err_ovf     (err_ovf)
  );

  always #5 clk = ~clk;

  // Downstream SR latch driven by the DUT.
  always @(s or r) begin
    if (s) q_ff = 1'b1;
    else if (r) q_ff = 1'b0;
  end

  task automatic chk(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", tag, got, exp, $time);
    end
  endtask

  always @(s or r) begin
    if (s && r) chk("s_and_r_mon", s & r, 1'b0);
  end

  // Reference model: a queue of upcoming per-cycle outputs.
  typedef struct packed {
    logic s;
    logic r;
    logic sh;
  } ent_t;

  ent_t mq[$];
  int   pend;
  logic cmd_sh;
  logic m_s, m_r, m_busy, m_sh, m_cf, m_of;

  task automatic model_reset();
    ent_t e;
    mq.delete();
    for (int i = 0; i < PW; i++) begin
      e.s = 1'b0; e.r = 1'b1; e.sh = 1'b0;
      mq.push_back(e);
    end
    for (int i = 0; i < GW; i++) begin
      e.s = 1'b0; e.r = 1'b0; e.sh = 1'b0;
      mq.push_back(e);
    end
    pend   = 0;
    cmd_sh = 1'b0;
    m_s    = 1'b0;
    m_r    = 1'b0;
    m_busy = 1'b1;
    m_sh   = 1'b0;
    m_cf   = 1'b0;
    m_of   = 1'b0;
  endtask

  // code: 1=set 2=clr 3=toggle
  task automatic model_issue(input int code);
    ent_t e;
    logic k;
    k = (code == 1) ? 1'b1 : (code == 2) ? 1'b0 : !cmd_sh;
    for (int i = 0; i < PW; i++) begin
      e.s  = k;
      e.r  = !k;
      e.sh = (i == PW - 1) ? k : cmd_sh;
      mq.push_back(e);
    end
    for (int i = 0; i < GW; i++) begin
      e.s = 1'b0; e.r = 1'b0; e.sh = k;
      mq.push_back(e);
    end
    cmd_sh = k;
  endtask

  task automatic model_step(input logic si, input logic ci,
                            input logic ti, input logic fi);
    int   n;
    int   code;
    logic busy_now;
    logic exit_now;
    logic ovf;
    ent_t e;
    n    = int'(si) + int'(ci) + int'(ti);
    code = 0;
    if (n == 1) code = si ? 1 : (ci ? 2 : 3);
    busy_now = (mq.size() > 0);
    exit_now = (mq.size() == 1);
    ovf  = (code != 0) && busy_now && (pend != 0);
    m_cf = (n > 1) || (m_cf && !fi);
    m_of = ovf || (m_of && !fi);
    if (busy_now && code != 0) pend = code;
    if (busy_now) begin
      e = mq.pop_front();
      m_s = e.s; m_r = e.r; m_sh = e.sh; m_busy = 1'b1;
    end else begin
      m_s = 1'b0; m_r = 1'b0; m_sh = cmd_sh; m_busy = 1'b0;
    end
    if (!busy_now && code != 0) begin
      model_issue(code);
    end else if (exit_now && pend != 0) begin
      model_issue(pend);
      pend = 0;
    end
  endtask

  task automatic compare_all();
    chk("s", s, m_s);
    chk("r", r, m_r);
    chk("busy", busy, m_busy);
    chk("shadow_q", shadow_q, m_sh);
    chk("err_conflict", err_conflict, m_cf);
    chk("err_ovf", err_ovf, m_of);
    chk("s_and_r", s & r, 1'b0);
    if (!m_busy && !rst) chk("latch_q", q_ff, m_sh);
  endtask

  task automatic cycle(input logic si, input logic ci,
                       input logic ti, input logic fi);
    set_req   = si;
    clr_req   = ci;
    tog_req   = ti;
    clr_flags = fi;
    @(posedge clk);
    model_step(si, ci, ti, fi);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst       = 1'b1;
    set_req   = 1'b0;
    clr_req   = 1'b0;
    tog_req   = 1'b0;
    clr_flags = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    set_req   = 1'b0;
    clr_req   = 1'b0;
    tog_req   = 1'b0;
    clr_flags = 1'b0;
    do_reset();

    // Init sequence: r on cycles 1-2, gap on 3, idle from 4.
    idle(1); chk("init_r_c1", r, 1'b1);
    idle(1); chk("init_r_c2", r, 1'b1);
    idle(1); chk("init_r_c3", r, 1'b0);
    chk("init_busy_c3", busy, 1'b1);
    idle(1); chk("init_busy_c4", busy, 1'b0);
    chk("init_shadow", shadow_q, 1'b0);
    idle(2);

    // Single set pulse.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1); chk("set_s_n1", s, 1'b1);
    idle(1); chk("set_s_n2", s, 1'b1);
    idle(1); chk("set_guard_s", s, 1'b0);
    chk("set_guard_busy", busy, 1'b1);
    idle(1); chk("set_busy_n4", busy, 1'b0);
    chk("set_shadow_n4", shadow_q, 1'b1);
    chk("set_latch_q", q_ff, 1'b1);

    // Clear, then two toggles with the second pending.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(4);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("tog_gap_busy", busy, 1'b1);
    idle(1); chk("tog2_r", r, 1'b1);
    chk("tog2_busy", busy, 1'b1);
    idle(1);
    idle(1);
    idle(1); chk("tog2_shadow", shadow_q, 1'b0);
    chk("tog2_idle", busy, 1'b0);

    // Conflicting requests: no pulse, sticky until cleared.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("conf_flag", err_conflict, 1'b1);
    idle(1); chk("conf_no_busy", busy, 1'b0);
    chk("conf_no_s", s, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("conf_cleared", err_conflict, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    chk("conf_set_wins", err_conflict, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Overwrite of the pending slot: clr, set, tog while busy.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovf_flag", err_ovf, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1); chk("ovf_tog_r", r, 1'b1);
    idle(3); chk("ovf_shadow", shadow_q, 1'b0);
    chk("ovf_one_pulse", busy, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_cleared", err_ovf, 1'b0);
    idle(1);

    // Reset during the second cycle of an s pulse.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("rst_pre_s", s, 1'b1);
    do_reset();
    chk("rst_s_drop", s, 1'b0);
    idle(1); chk("rst_init_r", r, 1'b1);
    idle(4);

    // Random traffic with occasional mid-cycle resets.
    for (int i = 0; i < 3000; i++) begin
      int   p;
      logic si, ci, ti, fi;
      p  = int'($urandom_range(0, 99));
      si = 1'b0; ci = 1'b0; ti = 1'b0;
      if (p < 55) begin
      end else if (p < 70) begin
        si = 1'b1;
      end else if (p < 82) begin
        ci = 1'b1;
      end else if (p < 94) begin
        ti = 1'b1;
      end else if (p < 98) begin
        si = 1'($urandom_range(0, 1));
        ci = !si;
        ti = 1'b1;
      end else begin
        si = 1'b1; ci = 1'b1; ti = 1'b1;
      end
      fi = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 999) < 3) do_reset();
      else cycle(si, ci, ti, fi);
    end
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
